vga_fb_arbiter: RTL and testbench

Shares the single-port 256x128 pixel RAM (15-bit address, 6-bit RGB222) between the VGA scan-out path and a pixel writer, such as a pattern loader or UART image loader. Scan-out reads always win and have a fixed latency, so the display timing stays deterministic. Writer requests pass through a small FIFO and drain into the RAM on cycles the display does not use. A tear-free mode restricts writes to vertical blanking. The block sits between the VGA display timing block and the frame RAM, all on the 25 MHz pixel clock.

---
 rtl/vga_fb_arbiter.sv | 119 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame RAM arbiter: display scan-out reads take priority with a fixed 3-cycle latency,
// and writer pixels queue in a small FIFO that drains on cycles the display leaves idle.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk25M,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              vblank,
    input  logic              tear_free,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              wr_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } grant_t;

    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [1:0]        tag_reg;
    grant_t            grant;
    logic              push;
    logic              pop;

    // Ready depends only on the registered level, never on wr_valid.
    assign wr_ready   = (level_reg < LVL_W'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign pop        = (grant == GNT_WRITE);
    assign fifo_level = level_reg;
    assign wr_busy    = (level_reg != '0);

    always_comb begin
        grant = GNT_IDLE;
        if (disp_req) begin
            grant = GNT_READ;
        end else if ((level_reg != '0) && (!tear_free || vblank)) begin
            grant = GNT_WRITE;
        end
    end

    // FIFO storage carries no reset; only pointers and level define its contents.
    always_ff @(posedge clk25M) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= wr_addr;
            fifo_data_mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // tag_reg[0] lines up with ram_addr, tag_reg[1] with ram_rdata.
    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            tag_reg     <= '0;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
        end else begin
            case (grant)
                GNT_READ: begin
                    ram_addr <= disp_addr;
                    ram_we   <= 1'b0;
                end
                GNT_WRITE: begin
                    ram_addr  <= fifo_addr_mem[rd_ptr_reg];
                    ram_wdata <= fifo_data_mem[rd_ptr_reg];
                    ram_we    <= 1'b1;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
            tag_reg     <= {tag_reg[0], (grant == GNT_READ)};
            disp_rvalid <= tag_reg[1];
            disp_rdata  <= tag_reg[1] ? ram_rdata : '0;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed stimulus feeds expectation queues; negedge monitors
// pop and compare every RAM write and every display read return.
module tb_vga_fb_arbiter;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = 3;

    logic              clk25M = 1'b0;
    logic              reset_n = 1'b0;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              vblank = 1'b0;
    logic              tear_free = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [LVL_W-1:0]  fifo_level;
    logic              wr_busy;

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
    ) dut (
        .clk25M(clk25M), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .vblank(vblank), .tear_free(tear_free),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_level(fifo_level), .wr_busy(wr_busy)
    );

    always #20 clk25M = ~clk25M;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rd_exp_t;

    rd_exp_t                  exp_r[$];
    logic [ADDR_W+DATA_W-1:0] exp_w[$];
    logic [DATA_W-1:0]        mem [1 << ADDR_W];
    int                       n_checks = 0;
    int                       n_fail = 0;
    int                       cyc = 0;
    logic                     prev_req = 1'b0;

    // Reference picture preloaded into the RAM model; read addresses are never written.
    function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
        if (a == 15'h1234) return 6'h2A;
        return a[5:0] ^ a[11:6];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous RAM model, read-before-write.
    always @(posedge clk25M) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        cyc       <= cyc + 1;
        prev_req  <= disp_req;
        if (reset_n && disp_req) exp_r.push_back('{pix(disp_addr), cyc + 3});
    end

    always @(negedge clk25M) begin
        if (reset_n) begin
            if (ram_we) begin
                check("no_write_during_read", 32'(prev_req), 32'd0);
                if (exp_w.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", ram_addr, ram_wdata);
                end else begin
                    logic [ADDR_W+DATA_W-1:0] w;
                    w = exp_w.pop_front();
                    check("write_addr", 32'(ram_addr), 32'(w[ADDR_W+DATA_W-1:DATA_W]));
                    check("write_data", 32'(ram_wdata), 32'(w[DATA_W-1:0]));
                    $display("write  cycle=%0d addr=0x%04h data=0x%02h", cyc, ram_addr, ram_wdata);
                end
            end
            if (disp_rvalid) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_read: got data 0x%0h, expected no rvalid", disp_rdata);
                end else begin
                    rd_exp_t r;
                    r = exp_r.pop_front();
                    check("read_data", 32'(disp_rdata), 32'(r.data));
                    check("read_latency", 32'(cyc), 32'(r.due));
                    $display("read   cycle=%0d data=0x%02h", cyc, disp_rdata);
                end
            end else begin
                check("black_when_invalid", 32'(disp_rdata), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk25M);
    endtask

    task automatic wait_accept();
        for (int k = 0; k < 20 && !wr_ready; k++) @(negedge clk25M);
        if (!wr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got wr_ready 0, expected 1 within 20 cycles");
        end else begin
            @(negedge clk25M);
        end
        wr_valid = 1'b0;
    endtask

    task automatic offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit track);
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        if (track) exp_w.push_back({a, d});
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit track);
        offer(a, d, track);
        wait_accept();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_disp_rdata"}, 32'(disp_rdata), 32'd0);
        check({tag, "_disp_rvalid"}, 32'(disp_rvalid), 32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
        check({tag, "_wr_busy"}, 32'(wr_busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion before 400us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pix(ADDR_W'(i));

        tick(3);
        check_reset_values("in_reset");
        reset_n = 1'b1;
        tick(1);
        check_reset_values("after_reset");
        check("after_reset_wr_ready", 32'(wr_ready), 32'd1);

        // Read latency and back-to-back reads, including address extremes.
        disp_req  = 1'b1;
        disp_addr = 15'h1234;
        tick(1);
        check("read_ram_addr", 32'(ram_addr), 32'h1234);
        disp_addr = 15'h0000;
        tick(1);
        disp_addr = 15'h7FFF;
        tick(1);
        disp_addr = 15'h0ABC;
        tick(1);
        disp_req = 1'b0;
        tick(5);

        // Idle writes drain on consecutive cycles.
        send(15'h0005, 6'h3F, 1'b1);
        send(15'h0006, 6'h01, 1'b1);
        check("idle_we_first", 32'(ram_we), 32'd1);
        tick(1);
        check("idle_we_second", 32'(ram_we), 32'd1);
        tick(1);
        check("idle_we_done", 32'(ram_we), 32'd0);
        check("idle_level_zero", 32'(fifo_level), 32'd0);

        // Display reads hold off queued writes.
        disp_req  = 1'b1;
        disp_addr = 15'h0100;
        send(15'h0010, 6'h2C, 1'b1);
        send(15'h0011, 6'h13, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("prio_no_we", 32'(ram_we), 32'd0);
            tick(1);
        end
        check("prio_level_two", 32'(fifo_level), 32'd2);
        check("prio_busy", 32'(wr_busy), 32'd1);
        disp_req = 1'b0;
        tick(1);
        check("prio_we_first", 32'(ram_we), 32'd1);
        tick(1);
        check("prio_we_second", 32'(ram_we), 32'd1);
        tick(1);
        check("prio_level_zero", 32'(fifo_level), 32'd0);
        tick(3);

        // Tear-free: writes wait for vblank.
        tear_free = 1'b1;
        send(15'h2000, 6'h11, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("tearfree_no_we", 32'(ram_we), 32'd0);
            tick(1);
        end
        check("tearfree_level_one", 32'(fifo_level), 32'd1);
        vblank = 1'b1;
        tick(1);
        check("tearfree_we_in_vblank", 32'(ram_we), 32'd1);
        vblank = 1'b0;
        tick(1);
        check("tearfree_level_zero", 32'(fifo_level), 32'd0);

        // Full FIFO backpressure, then drain while the writer keeps offering.
        for (int i = 0; i < 4; i++) send(15'h3000 + 15'(i), 6'h20 + 6'(i), 1'b1);
        offer(15'h3004, 6'h24, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check("full_wr_ready_low", 32'(wr_ready), 32'd0);
            check("full_level_four", 32'(fifo_level), 32'd4);
            tick(1);
        end
        vblank = 1'b1;
        wait_accept();
        check("pushpop_level_p4", 32'(fifo_level), 32'd3);
        send(15'h3005, 6'h25, 1'b1);
        check("pushpop_level_p5", 32'(fifo_level), 32'd3);
        tick(5);
        check("full_drained", 32'(fifo_level), 32'd0);
        vblank = 1'b0;

        // Asynchronous reset mid-traffic discards queued writes and in-flight reads.
        for (int i = 0; i < 3; i++) send(15'h4000 + 15'(i), 6'h30 + 6'(i), 1'b0);
        check("pre_reset_level", 32'(fifo_level), 32'd3);
        disp_req  = 1'b1;
        disp_addr = 15'h0040;
        tick(2);
        #5;
        reset_n = 1'b0;
        exp_r.delete();
        #1;
        check_reset_values("async_reset");
        disp_req = 1'b0;
        tick(1);
        reset_n   = 1'b1;
        tear_free = 1'b0;
        tick(1);
        check("post_reset_level", 32'(fifo_level), 32'd0);
        check("post_reset_wr_ready", 32'(wr_ready), 32'd1);
        check("post_reset_busy", 32'(wr_busy), 32'd0);
        tick(4);
        check("post_reset_no_we", 32'(ram_we), 32'd0);

        check("writes_outstanding", 32'(exp_w.size()), 32'd0);
        check("reads_outstanding", 32'(exp_r.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
